// File: rtl/pool_fmap_buffer.sv
// Purpose: captures the pooled pixel stream into a MAP_W x MAP_H raster memory
//          and serves it to the dense/flatten stage through a synchronous read port.
// Latency: rd_data follows rd_addr by one clock; done/map_ready are registered
//          on the edge that stores the last pixel.
// Backpressure: none; beats arriving when no map is being filled are dropped,
//               and beats arriving after completion raise the sticky overflow flag.
// Ports: clk/rst (async active-low), start (re-arm pulse), in_data/in_valid (pixel stream),
//        rd_addr/rd_data (read port), wr_count, map_ready, done, overflow (status).
module pool_fmap_buffer #(
  parameter int DATA_W = 8,
  parameter int MAP_W  = 13,
  parameter int MAP_H  = 13,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_count,
  output logic              map_ready,
  output logic              done,
  output logic              overflow
);

  localparam int              DEPTH   = MAP_W * MAP_H;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              map_ready_nxt;
  logic              done_nxt;
  logic              overflow_nxt;
  logic              wr_en;

  logic [DATA_W-1:0] mem [DEPTH];

  // A start in the same cycle as a beat discards the beat, so it never lands
  // in the freshly armed map.
  assign wr_en = (state == FILL) && in_valid && !start && (wr_count < DEPTH_A);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = wr_count;
    map_ready_nxt = map_ready;
    done_nxt      = 1'b0;
    overflow_nxt  = overflow;

    if (start) begin
      state_nxt     = FILL;
      cnt_nxt       = '0;
      map_ready_nxt = 1'b0;
      overflow_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // stream is ignored until the buffer is armed
        end
        FILL: begin
          if (wr_en) begin
            cnt_nxt = wr_count + ADDR_W'(1);
            if (cnt_nxt == DEPTH_A) begin
              state_nxt     = READY;
              map_ready_nxt = 1'b1;
              done_nxt      = 1'b1;
            end
          end
        end
        READY: begin
          // map is frozen; count stays saturated at DEPTH
          if (in_valid) begin
            overflow_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_count  <= '0;
      map_ready <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_count  <= cnt_nxt;
      map_ready <= map_ready_nxt;
      done      <= done_nxt;
      overflow  <= overflow_nxt;
    end
  end

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_count] <= in_data;
    end
  end

  // Read happens on the same edge as any write, so a colliding address
  // returns the previous contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_addr < DEPTH_A) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule
